// File: rtl/mem_arb.sv
// Single-outstanding arbiter merging fetch, load and store traffic onto one memory port.
// Define ARB_RR_EN to alternate fetch/LSU priority on contested grants; otherwise LSU wins.
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ren,
    input  logic              imem_ready,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_rvalid,
    input  logic [ADDR_W-1:0] dmem_raddr,
    input  logic              dmem_ren,
    input  logic              dmem_rready,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_rvalid,
    input  logic [ADDR_W-1:0] dmem_waddr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [2:0]        dmem_wlen,
    input  logic              dmem_wen,
    input  logic              dmem_wvalid,
    output logic              dmem_wready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [2:0]        mem_req_wlen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              mem_resp_ready
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, RET} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, grant_owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        wlen_q;
    logic [DATA_W-1:0] rdata_q;
    logic              st_req, lsu_req, fetch_wins, grant, grant_store;

    assign st_req  = dmem_wen & dmem_wvalid;
    assign lsu_req = st_req | dmem_ren;

`ifdef ARB_RR_EN
    // lsu_turn names who wins the next fetch-vs-LSU contest.
    logic lsu_turn;
    assign fetch_wins = imem_ren & (~lsu_req | ~lsu_turn);
`else
    assign fetch_wins = imem_ren & ~lsu_req;
`endif

    assign grant       = (state == IDLE) & (imem_ren | lsu_req);
    assign grant_owner = fetch_wins ? OWN_IF : (st_req ? OWN_ST : OWN_LD);
    assign grant_store = (grant_owner == OWN_ST);

    // NOTE: next-state defaults to the current state first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant)          state_nxt = REQ;
            REQ:  if (mem_req_ready)  state_nxt = RESP;
            RESP: if (mem_resp_valid) state_nxt = RET;
            RET: begin
                case (owner)
                    OWN_IF:  if (imem_ready)  state_nxt = IDLE;
                    OWN_LD:  if (dmem_rready) state_nxt = IDLE;
                    default:                  state_nxt = IDLE;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wlen_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner   <= grant_owner;
                addr_q  <= fetch_wins ? imem_addr : (st_req ? dmem_waddr : dmem_raddr);
                wen_q   <= grant_store;
                wdata_q <= grant_store ? dmem_wdata : '0;
                wlen_q  <= grant_store ? dmem_wlen : 3'd0;
            end
            if (state == RESP && mem_resp_valid) rdata_q <= mem_resp_rdata;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              lsu_turn <= 1'b1;
        else if (grant & imem_ren & lsu_req)  lsu_turn <= fetch_wins;
    end
`endif

    // Responses are decoded from state and owner, so a reset can never leave one asserted.
    assign mem_req_valid  = (state == REQ);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wlen   = wlen_q;
    assign mem_resp_ready = (state == RESP) | (state == IDLE);
    assign imem_rvalid    = (state == RET) & (owner == OWN_IF);
    assign dmem_rvalid    = (state == RET) & (owner == OWN_LD);
    assign dmem_wready    = (state == RET) & (owner == OWN_ST);
    assign imem_rdata     = rdata_q;
    assign dmem_rdata     = rdata_q;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: ysyx_25040109_MEM_ARB

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width on all ports.
REQ-003 SHALL provide the following ports; the design has one clock, and reset is asynchronous and active-high:
  clk  in  1  clock; all state updates on its rising edge.
  rst  in  1  asynchronous active-high reset.
  imem_addr  in  ADDR_W  fetch address.
  imem_ren  in  1  fetch request; held until the response is accepted.
  imem_ready  in  1  fetch side accepts the response.
  imem_rdata  out  DATA_W  fetched instruction.
  imem_rvalid  out  1  fetch response valid.
  dmem_raddr  in  ADDR_W  load address.
  dmem_ren  in  1  load request, level.
  dmem_rready  in  1  load side accepts the response.
  dmem_rdata  out  DATA_W  load data.
  dmem_rvalid  out  1  load response valid.
  dmem_waddr  in  ADDR_W  store address.
  dmem_wdata  in  DATA_W  store data.
  dmem_wlen  in  3  store byte count (1/2/4).
  dmem_wen, dmem_wvalid  in  1 each  store request when both are 1.
  dmem_wready  out  1  one-cycle store-complete pulse.
  mem_req_valid  out  1  downstream request valid.
  mem_req_ready  in  1  downstream request accepted.
  mem_req_addr  out  ADDR_W  downstream request address.
  mem_req_wen  out  1  1 = write, 0 = read.
  mem_req_wdata  out  DATA_W  downstream write data.
  mem_req_wlen  out  3  downstream write length.
  mem_resp_valid  in  1  downstream response (read data or write ack).
  mem_resp_rdata  in  DATA_W  downstream read data.
  mem_resp_ready  out  1  arbiter accepts the downstream response.

Function
REQ-004 SHALL use FSM states IDLE, REQ, RESP, RET; at most one downstream transaction outstanding.
REQ-005 IDLE: SHALL grant when a request is pending; LSU store (dmem_wen&&dmem_wvalid) > LSU load > fetch, subject to REQ-017.
REQ-006 On grant SHALL latch owner, address, wen, wdata, wlen, then go to REQ; upstream changes after grant SHALL be ignored.
REQ-007 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready; fire -> RESP.
REQ-008 RESP: mem_resp_ready=1; on mem_resp_valid SHALL latch mem_resp_rdata -> RET.
REQ-009 RET with read owner: SHALL assert the owner's rvalid with latched data, held until that owner's ready=1; that cycle -> IDLE.
REQ-010 RET with store owner: SHALL pulse dmem_wready for exactly one cycle -> IDLE.
REQ-011 Minimum latency, request seen to upstream valid: 4 cycles (grant, req fire, resp, RET).
REQ-012 A request arriving while busy SHALL wait; no request is dropped or duplicated.
REQ-013 mem_resp_valid outside RESP SHALL be ignored; mem_resp_ready=1 in IDLE drains stale responses.
REQ-014 rvalid/wready SHALL never go to a non-owner; imem_rvalid and dmem_rvalid SHALL never be 1 together.

Reset
REQ-015 On rst, asynchronously: state=IDLE; mem_req_valid, imem_rvalid, dmem_rvalid, dmem_wready=0; latched data=0; mem_resp_ready=1.
REQ-016 rst mid-transaction SHALL abandon it, with no upstream response issued afterwards.

Configuration
REQ-017 Macro ARB_RR_EN defined: fetch vs. LSU priority SHALL alternate, with the loser of the last contested grant winning the next contest; store still precedes load within LSU. Undefined: fixed priority of REQ-005.

Verification
REQ-018 Fetch only, addr 0x80000000, mem returns 0x00000413 with 0 wait -> imem_rvalid on cycle 4 with rdata 0x00000413.
REQ-019 Store addr 0x80001000, wdata 0xDEADBEEF, wlen 4 -> one mem_req with wen=1 and matching fields; dmem_wready pulses 1 cycle after the ack.
REQ-020 Fetch and load asserted in the same cycle, no ARB_RR_EN -> load served first, fetch second; with ARB_RR_EN, two back-to-back contests alternate the winner.
REQ-021 mem_req_ready low 5 cycles, imem_ready low 3 cycles in RET -> request fields and rvalid/data held stable, with no second transaction.
REQ-022 rst asserted in RESP, then a stray mem_resp_valid -> no rvalid or wready issued; a subsequent fetch completes normally.
